// File: rtl/crc_frame_sched.sv
`timescale 1ns/1ps
// crc_frame_sched: round-robin transmit scheduler for the RS-485 link.
// Feeds the shared CRC-16 framing unit, checks the returned payload field,
// streams the 5-byte {payload, crc} frame to the UART and owns the driver
// enable with guard intervals before and after each frame.
module crc_frame_sched #(
    parameter int NREQ      = 2,
    parameter int GUARD_CYC = 16,
    parameter int IDW       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [24*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [23:0]          crc_data_in,
    input  logic [39:0]          crc_out_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic                 tx_busy,
    output logic                 de,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 crc_err
);
    localparam int CW = $clog2(GUARD_CYC + 2);

    typedef enum logic [2:0] {
        IDLE, WAIT_CRC, PRE_GUARD, SEND, DRAIN, POST_GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           byte_q, byte_d;
    logic [39:0]          frame_q, frame_d;
    logic [23:0]          pay_q, pay_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gid_q, gid_d;
    logic [NREQ-1:0]      rdy_q, rdy_d;
    logic                 err_q, err_d;

    logic [NREQ-1:0][23:0] pay_v;
    logic                  found;
    logic [IDW-1:0]        win;
    logic [IDW-1:0]        idx;

    assign pay_v = req_data;

    // Round-robin search: first pending requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(ptr_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        pay_d   = pay_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        rdy_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    rdy_d[win] = 1'b1;
                    pay_d      = pay_v[win];
                    gid_d      = win;
                    ptr_d      = IDW'((32'(win) + 32'd1) % NREQ);
                    cnt_d      = '0;
                    state_d    = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                // CRC unit result is valid from the second cycle; sample at exit.
                if (cnt_q == CW'(1)) begin
                    cnt_d = '0;
                    if (crc_out_data[39:16] != pay_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_d = crc_out_data;
                        state_d = PRE_GUARD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRE_GUARD: begin
                if (cnt_q == CW'(GUARD_CYC - 1)) begin
                    cnt_d   = '0;
                    byte_d  = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_q == 3'd4) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                // First DRAIN cycle ignores tx_busy so a late busy rise is seen.
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = POST_GUARD;
                end
            end
            POST_GUARD: begin
                if (cnt_q == CW'(GUARD_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            pay_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            rdy_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            pay_q   <= pay_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    // Output decode from the registered state, so reset clears it immediately.
    always_comb begin
        busy     = (state_q != IDLE);
        de       = state_q inside {PRE_GUARD, SEND, DRAIN, POST_GUARD};
        tx_valid = (state_q == SEND);
        tx_data  = '0;
        if (state_q == SEND) begin
            case (byte_q)
                3'd0:    tx_data = frame_q[39:32];
                3'd1:    tx_data = frame_q[31:24];
                3'd2:    tx_data = frame_q[23:16];
                3'd3:    tx_data = frame_q[15:8];
                default: tx_data = frame_q[7:0];
            endcase
        end
    end

    assign req_ready   = rdy_q;
    assign crc_data_in = pay_q;
    assign grant_id    = gid_q;
    assign crc_err     = err_q;

endmodule

// File: tb/tb_crc_frame_sched.sv
`timescale 1ns/1ps
// Directed bench for crc_frame_sched with a behavioural CRC-16 unit and UART.
module tb_crc_frame_sched;
    localparam int NREQ  = 2;
    localparam int GUARD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [23:0] crc_data_in;
    logic [39:0] crc_out_data;
    logic [39:0] crc_reg;
    logic        corrupt = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic        de;
    logic        busy;
    logic [0:0]  grant_id;
    logic        crc_err;

    int n_checks = 0;
    int n_fail   = 0;

    crc_frame_sched #(.NREQ(NREQ), .GUARD_CYC(GUARD), .IDW(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .crc_data_in(crc_data_in), .crc_out_data(crc_out_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .de(de), .busy(busy), .grant_id(grant_id), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc16(input logic [23:0] d);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // External CRC unit: combinational CRC into a one-cycle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_reg <= '0;
        else     crc_reg <= {crc_data_in, crc16(crc_data_in)};
    end
    assign crc_out_data = corrupt ? {24'hFFFFFF, crc_reg[15:0]} : crc_reg;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_grant(output logic [1:0] rr, output logic gid, output bit to);
        to = 1'b1; rr = '0; gid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                rr = req_ready; gid = grant_id[0]; to = 1'b0;
                break;
            end
        end
    endtask

    // Plays the UART side of one frame and reports what it observed.
    task automatic stream_frame(input int rpat, input int hold,
            output logic [39:0] bytes, output int nb, output int pre, output int post,
            output int drain, output int scyc, output bit stable, output bit to);
        int k, left;
        bit done, stalled, started;
        logic [7:0] held;
        bytes = '0; nb = 0; pre = 0; post = 0; drain = 0; scyc = 0; stable = 1'b1; to = 1'b1;
        k = 0; left = 0; done = 1'b0; stalled = 1'b0; started = 1'b0; held = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                tx_busy = (left > 0);
                if (left > 0) left--;
            end
            if (tx_valid) begin
                started = 1'b1;
                scyc++;
                if (done || rpat == 0) tx_ready = 1'b1;
                else                   tx_ready = ((k % rpat) == rpat - 1);
                k++;
                if (stalled && tx_data !== held) stable = 1'b0;
                if (tx_ready) begin
                    bytes = {bytes[31:0], tx_data};
                    nb++;
                    stalled = 1'b0;
                    if (nb == 5) begin done = 1'b1; left = hold; end
                end else begin
                    stalled = 1'b1;
                    held = tx_data;
                end
            end else begin
                tx_ready = 1'b0;
                if (!started && de) pre++;
                if (done) begin
                    if (!de) begin to = 1'b0; break; end
                    if (tx_busy) drain++;
                    else         post++;
                end
            end
        end
        tx_ready = 1'b0;
        tx_busy = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        req_data = {24'h000002, 24'h000001};
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_checks++; if ({de, busy, tx_valid, crc_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got de/busy/txv/err=%b expected 0000", {de, busy, tx_valid, crc_err}); end
        n_checks++; if ({crc_data_in, tx_data, grant_id} !== 33'd0) begin n_fail++; $display("FAIL reset_data: got crc_in=%h tx=%h gid=%h expected 0", crc_data_in, tx_data, grant_id); end
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, req_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got busy/rdy=%b expected 000", {busy, req_ready}); end
    endtask

    task automatic test_single_frame;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        req_data = {24'h000002, 24'h000001};
        req_valid = 2'b01;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_grant_timeout: no req_ready seen"); end
        n_checks++; if (rr !== 2'b01 || gid !== 1'b0) begin n_fail++; $display("FAIL single_grant: got rdy=%b gid=%b expected 01/0", rr, gid); end
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00 || de !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got rdy=%b de=%b expected 00/0", req_ready, de); end
        stream_frame(0, 3, b, nb, pre, post, dr, sc, st, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_stream_timeout: frame did not complete"); end
        n_checks++; if (b !== 40'h00_00_01_10_21 || nb !== 5) begin n_fail++; $display("FAIL single_bytes: got %h (%0d bytes) expected 0000011021 (5)", b, nb); end
        n_checks++; if (pre !== 16) begin n_fail++; $display("FAIL single_pre_guard: got %0d expected 16", pre); end
        n_checks++; if (dr !== 3 || post !== 17) begin n_fail++; $display("FAIL single_post_guard: got drain=%0d post=%0d expected 3/17", dr, post); end
        n_checks++; if (sc !== 5) begin n_fail++; $display("FAIL single_back_to_back: got %0d send cycles expected 5", sc); end
        n_checks++; if (grant_id !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_end: got gid=%b busy=%b expected 0/0", grant_id, busy); end
    endtask

    task automatic test_backpressure;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        req_valid = 2'b10;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0 || rr !== 2'b10 || gid !== 1'b1) begin n_fail++; $display("FAIL bp_grant: got to=%b rdy=%b gid=%b expected 0/10/1", to, rr, gid); end
        stream_frame(3, 2, b, nb, pre, post, dr, sc, st, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: frame did not complete"); end
        n_checks++; if (b !== 40'h00_00_02_20_42 || nb !== 5) begin n_fail++; $display("FAIL bp_bytes: got %h (%0d bytes) expected 0000022042 (5)", b, nb); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: tx_data changed while stalled, got 0 expected 1"); end
        n_checks++; if (sc !== 15) begin n_fail++; $display("FAIL bp_send_cycles: got %0d expected 15", sc); end
    endtask

    task automatic test_round_robin;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        logic eg;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_data = {24'h000002, 24'h000001};
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            eg = (f % 2) == 1;
            wait_grant(rr, gid, to);
            n_checks++; if (to !== 1'b0 || gid !== eg || rr !== (eg ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant%0d: got to=%b rdy=%b gid=%b expected gid %b", f, to, rr, gid, eg); end
            n_checks++; if (crc_data_in !== (eg ? 24'h000002 : 24'h000001)) begin n_fail++; $display("FAIL rr_payload%0d: got %h", f, crc_data_in); end
            stream_frame(0, 1, b, nb, pre, post, dr, sc, st, to);
            n_checks++; if (to !== 1'b0 || b !== (eg ? 40'h0000022042 : 40'h0000011021)) begin n_fail++; $display("FAIL rr_frame%0d: got %h to=%b", f, b, to); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_crc_mismatch;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        bit seen;
        req_data = {24'h000002, 24'h123456};
        req_valid = 2'b01;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        corrupt = 1'b1;
        n_checks++; if (to !== 1'b0 || rr !== 2'b01) begin n_fail++; $display("FAIL crc_grant: got to=%b rdy=%b expected 0/01", to, rr); end
        @(negedge clk);
        n_checks++; if (crc_err !== 1'b0) begin n_fail++; $display("FAIL crc_early_err: got %b expected 0", crc_err); end
        @(negedge clk);
        corrupt = 1'b0;
        n_checks++; if (crc_err !== 1'b1) begin n_fail++; $display("FAIL crc_err_pulse: got %b expected 1", crc_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL crc_idle: got busy %b expected 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (de || tx_valid || crc_err) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL crc_quiet: got de/tx_valid/err activity 1 expected 0"); end
        req_valid = 2'b11;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0 || rr !== 2'b10 || gid !== 1'b1) begin n_fail++; $display("FAIL crc_ptr_advanced: got rdy=%b gid=%b expected 10/1", rr, gid); end
        stream_frame(0, 1, b, nb, pre, post, dr, sc, st, to);
        n_checks++; if (to !== 1'b0 || b !== 40'h0000022042) begin n_fail++; $display("FAIL crc_next_frame: got %h to=%b expected 0000022042", b, to); end
    endtask

    task automatic test_reset_mid_send;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        int acc;
        req_data = {24'h000002, 24'h000001};
        req_valid = 2'b01;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0 || rr !== 2'b01) begin n_fail++; $display("FAIL mid_grant: got to=%b rdy=%b expected 0/01", to, rr); end
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            if (tx_valid) acc++;
            if (acc == 2) break;
        end
        @(negedge clk);
        n_checks++; if (de !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h01) begin n_fail++; $display("FAIL mid_third_byte: got de=%b txv=%b tx=%h expected 1/1/01", de, tx_valid, tx_data); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({de, tx_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_async_reset: got de/txv/busy=%b expected 000", {de, tx_valid, busy}); end
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0 || rr !== 2'b01 || gid !== 1'b0) begin n_fail++; $display("FAIL mid_ptr_reset: got rdy=%b gid=%b expected 01/0", rr, gid); end
        n_checks++; if (crc_data_in !== 24'h000001) begin n_fail++; $display("FAIL mid_payload: got %h expected 000001", crc_data_in); end
        stream_frame(0, 1, b, nb, pre, post, dr, sc, st, to);
        n_checks++; if (to !== 1'b0 || b !== 40'h0000011021 || nb !== 5) begin n_fail++; $display("FAIL mid_recovery_frame: got %h (%0d) expected 0000011021", b, nb); end
    endtask

    task automatic test_zero_payload;
        logic [39:0] b; int nb, pre, post, dr, sc; bit st, to; logic [1:0] rr; logic gid;
        req_data = {24'h000000, 24'h000001};
        req_valid = 2'b10;
        wait_grant(rr, gid, to);
        req_valid = 2'b00;
        n_checks++; if (to !== 1'b0 || rr !== 2'b10) begin n_fail++; $display("FAIL zero_grant: got to=%b rdy=%b expected 0/10", to, rr); end
        stream_frame(0, 40, b, nb, pre, post, dr, sc, st, to);
        n_checks++; if (to !== 1'b0 || b !== 40'h0 || nb !== 5) begin n_fail++; $display("FAIL zero_bytes: got %h (%0d) expected 0000000000 (5)", b, nb); end
        n_checks++; if (dr !== 40) begin n_fail++; $display("FAIL zero_drain_hold: got %0d expected 40", dr); end
        n_checks++; if (post !== 17 || pre !== 16) begin n_fail++; $display("FAIL zero_guards: got pre=%0d post=%0d expected 16/17", pre, post); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_round_robin();
        test_crc_mismatch();
        test_reset_mid_send();
        test_zero_payload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
